ddr_amm_responder: RTL and testbench
====================================

# ddr_amm_responder

Avalon-MM burst responder standing in for the DDR EMIF user port during bring-up and simulation. Accepts 256-bit write and read bursts from the DDR setup master on one clock. Backs them with an on-chip byte-enabled RAM. Also produces the calibration-status and ram-ready handshakes the master waits on before issuing traffic.

## Interface
Parameters:
- MEM_AW, 10: RAM word-address width; depth is 2^MEM_AW words of 256 bits.
- CAL_CYCLES, 64: clk cycles from reset release to calibration complete; minimum 1.
- CAL_FAIL, 0: when 1, calibration reports fail and the port never becomes ready.

Ports:
- clk, in, 1: single clock for the whole block.
- rst_n, in, 1: asynchronous, active-low reset.
- amm_addr, in, 25: word address; only [MEM_AW-1:0] is used, upper bits ignored.
- amm_writedata, in, 256: write beat data.
- amm_byteenable, in, 32: bit i enables writedata[8i+7:8i].
- amm_write, in, 1: write beat request.
- amm_read, in, 1: read burst command.
- amm_burstcount, in, 7: beats per burst, 1..64.
- amm_ready, out, 1: active-high ready (inverse waitrequest).
- amm_readdata, out, 256: read beat data.
- amm_readdatavalid, out, 1: amm_readdata is valid this cycle.
- local_cal_success, out, 1: calibration passed.
- local_cal_fail, out, 1: calibration failed.
- ram_ready, out, 1: memory usable.

## Operation
- States: CAL, IDLE, WR_BURST, RD_BURST, FAIL.
- Reset behaviour:
  - Reset value of every output is 0.
  - Reset enters CAL, whether asynchronous or mid-burst. Any in-flight burst is abandoned.
  - RAM contents are not reset.
- CAL:
  - The counter counts CAL_CYCLES cycles after rst_n deasserts.
  - With CAL_FAIL=0: go to IDLE and assert local_cal_success, ram_ready and amm_ready.
  - With CAL_FAIL=1: go to FAIL and assert local_cal_fail. FAIL is terminal until reset.
- Beat acceptance: a beat or command is accepted when the request is high and amm_ready is high.
- Write:
  - The first accepted write in IDLE latches addr[MEM_AW-1:0] and burstcount N.
  - Beat k writes RAM word (addr+k) mod 2^MEM_AW under byteenable.
  - N=1 stays in IDLE. N>1 enters WR_BURST until N beats are accepted, then returns to IDLE.
  - Gaps, i.e. amm_write low mid-burst, are allowed.
  - In WR_BURST, amm_addr, amm_burstcount and amm_read are ignored.
- Read:
  - An accepted read in IDLE latches addr and N, then enters RD_BURST.
  - Beats return in order from (addr+k) mod 2^MEM_AW, back-to-back.
- Burstcount rules:
  - burstcount 0 is treated as 1.
  - Values above 64 are truncated to the low 6 bits, with 0 meaning 64.
- amm_read and amm_write high together in IDLE: the write wins and the read is dropped.
- Address arithmetic is MEM_AW-bit modulo; wrap-around is silent.

## Timing
- amm_ready:
  - High in IDLE and WR_BURST.
  - Low in CAL, FAIL and RD_BURST.
  - Drops in the cycle after the read command is accepted.
- Write: RAM is written in the accept cycle. A read issued in the following cycle observes the data.
- Read, command accepted at cycle T:
  - RAM addresses are issued T+1..T+N, with a registered RAM output.
  - amm_readdatavalid is high exactly T+2..T+N+1.
  - amm_ready returns high at T+N+2.
- local_cal_success and ram_ready rise at the same edge as amm_ready, CAL_CYCLES cycles after reset release. All three hold until reset.

## Configuration
- AMM_RESP_PROTOCOL_CHECK_EN:
  - When defined, adds output protocol_err (1 bit, reset 0, sticky until reset).
  - It is set by: burstcount 0 or >64 at command accept; read and write together in IDLE; amm_read high in WR_BURST; any request high in CAL or FAIL.
- Without the macro: no port and no check logic, and data-path behaviour is identical.

## Structure
- Package ddr_amm_resp_pkg holds:
  - State enum.
  - AMM_ADDR_W=25, AMM_DATA_W=256, AMM_BE_W=32, AMM_BC_W=7, MAX_BURST=64.
- Sub-module ddr_amm_resp_ram: simple dual-port RAM with byte-enable write and a registered read (1-cycle latency), parameterized on MEM_AW.
- Top level holds the FSM, the calibration counter, and the beat and address counters.

## Test plan
- Reset release with CAL_CYCLES=64 -> all outputs 0 for 64 cycles, then local_cal_success, ram_ready and amm_ready high together; local_cal_fail stays 0.
- Write burst N=4 at addr 0x10 with data 0xA0..0xA3 and full byteenable, then read N=4 at 0x10 issued at T -> readdatavalid T+2..T+5 with 0xA0..0xA3 in order; amm_ready low T+1..T+5.
- Write 0xFF..FF to word 5, then write with byteenable=0x0000_0001 and data 0 -> read of word 5 returns 0xFF..FF00.
- Burst N=3 at addr 2^MEM_AW-2 -> beats land at words 1022, 1023, 0; readback matches.
- Assert rst_n low during the read beat 2 of 8 -> readdatavalid and amm_ready drop immediately; after CAL_CYCLES, a fresh read returns data written before reset.
- CAL_FAIL=1 -> local_cal_fail=1, amm_ready stays 0 indefinitely. With AMM_RESP_PROTOCOL_CHECK_EN defined, a read asserted in FAIL sets protocol_err.

Source files
------------

// File: rtl/ddr_amm_resp_pkg.sv
// Types and constants shared by the DDR Avalon-MM bring-up responder.
package ddr_amm_resp_pkg;

   localparam int AMM_ADDR_W = 25;
   localparam int AMM_DATA_W = 256;
   localparam int AMM_BE_W   = 32;
   localparam int AMM_BC_W   = 7;
   localparam int MAX_BURST  = 64;

   typedef enum logic [2:0] {
      ST_CAL,
      ST_IDLE,
      ST_WR_BURST,
      ST_RD_BURST,
      ST_FAIL
   } state_t;

   // Zero means one beat; oversize counts keep their low six bits, whose zero case is 64 itself.
   function automatic logic [AMM_BC_W-1:0] burst_len(input logic [AMM_BC_W-1:0] bc);
      logic [AMM_BC_W-1:0] len;
      if (bc == '0) begin
         len = AMM_BC_W'(1);
      end else if (bc > AMM_BC_W'(MAX_BURST)) begin
         len = {1'b0, bc[5:0]};
      end else begin
         len = bc;
      end
      return len;
   endfunction

endpackage

// File: rtl/ddr_amm_resp_ram.sv
// Byte-enabled simple dual-port RAM; read data registered, valid the cycle after rd_en.
// No backpressure: one write and one read may be issued every cycle.
module ddr_amm_resp_ram
   import ddr_amm_resp_pkg::*;
#(
   parameter int MEM_AW = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [MEM_AW-1:0]     wr_addr,
   input  logic [AMM_BE_W-1:0]   wr_be,
   input  logic [AMM_DATA_W-1:0] wr_dat,
   input  logic                  rd_en,
   input  logic [MEM_AW-1:0]     rd_addr,
   output logic [AMM_DATA_W-1:0] rd_dat
);

   logic [AMM_DATA_W-1:0] mem_q [2**MEM_AW];
   logic [AMM_DATA_W-1:0] rd_dat_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < AMM_BE_W; i++) begin
            if (wr_be[i]) begin
               mem_q[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
            end
         end
      end
   end

   // Only the output register is reset; the array keeps its contents across reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_dat_q <= '0;
      end else if (rd_en) begin
         rd_dat_q <= mem_q[rd_addr];
      end
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/ddr_amm_responder.sv
// Avalon-MM burst responder for the DDR setup master: reads return at T+2..T+N+1, amm_ready low in CAL/FAIL/RD_BURST.
// Define AMM_RESP_PROTOCOL_CHECK_EN to add the sticky protocol_err output.
module ddr_amm_responder
   import ddr_amm_resp_pkg::*;
#(
   parameter int MEM_AW     = 10,
   parameter int CAL_CYCLES = 64,
   parameter int CAL_FAIL   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [AMM_ADDR_W-1:0] amm_addr,
   input  logic [AMM_DATA_W-1:0] amm_writedata,
   input  logic [AMM_BE_W-1:0]   amm_byteenable,
   input  logic                  amm_write,
   input  logic                  amm_read,
   input  logic [AMM_BC_W-1:0]   amm_burstcount,
   output logic                  amm_ready,
   output logic [AMM_DATA_W-1:0] amm_readdata,
   output logic                  amm_readdatavalid,
   output logic                  local_cal_success,
   output logic                  local_cal_fail,
   output logic                  ram_ready
`ifdef AMM_RESP_PROTOCOL_CHECK_EN
   ,
   output logic                  protocol_err
`endif
);

   localparam int CAL_W = $clog2(CAL_CYCLES + 1);

   state_t                state_q, state_d;
   logic [CAL_W-1:0]      cal_cnt_q, cal_cnt_d;
   logic [MEM_AW-1:0]     base_q, base_d;
   logic [AMM_BC_W-1:0]   len_q, len_d;
   logic [AMM_BC_W-1:0]   cnt_q, cnt_d;
   logic                  rdy_q, rdy_d;
   logic                  rvld_q, rvld_d;
   logic                  cal_ok_q, cal_ok_d;
   logic                  cal_fail_q, cal_fail_d;

   logic                  acc_wr, acc_rd;
   logic [AMM_BC_W-1:0]   cmd_len;
   logic                  wr_en, rd_en;
   logic [MEM_AW-1:0]     wr_addr, rd_addr;
   logic [AMM_ADDR_W-MEM_AW-1:0] unused_addr_hi;

   assign unused_addr_hi = amm_addr[AMM_ADDR_W-1:MEM_AW];
   assign acc_wr  = amm_write & rdy_q;
   assign acc_rd  = amm_read & rdy_q;
   assign cmd_len = burst_len(amm_burstcount);

   always_comb begin
      state_d    = state_q;
      cal_cnt_d  = cal_cnt_q;
      base_d     = base_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      rdy_d      = rdy_q;
      cal_ok_d   = cal_ok_q;
      cal_fail_d = cal_fail_q;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      wr_addr    = base_q + MEM_AW'(cnt_q);
      rd_addr    = base_q + MEM_AW'(cnt_q);
      case (state_q)
         ST_CAL: begin
            if (cal_cnt_q == CAL_W'(CAL_CYCLES - 1)) begin
               if (CAL_FAIL != 0) begin
                  state_d    = ST_FAIL;
                  cal_fail_d = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
                  cal_ok_d = 1'b1;
                  rdy_d    = 1'b1;
               end
            end else begin
               cal_cnt_d = cal_cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            // A write beat takes priority; a simultaneous read command is dropped.
            if (acc_wr) begin
               wr_en   = 1'b1;
               wr_addr = amm_addr[MEM_AW-1:0];
               base_d  = amm_addr[MEM_AW-1:0];
               len_d   = cmd_len;
               cnt_d   = AMM_BC_W'(1);
               if (cmd_len != AMM_BC_W'(1)) state_d = ST_WR_BURST;
            end else if (acc_rd) begin
               base_d  = amm_addr[MEM_AW-1:0];
               len_d   = cmd_len;
               cnt_d   = '0;
               rdy_d   = 1'b0;
               state_d = ST_RD_BURST;
            end
         end
         ST_WR_BURST: begin
            if (acc_wr) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == len_q) state_d = ST_IDLE;
            end
         end
         ST_RD_BURST: begin
            // One extra cycle after the last address lets the final beat drain before ready returns.
            if (cnt_q != len_q) begin
               rd_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end else begin
               state_d = ST_IDLE;
               rdy_d   = 1'b1;
            end
         end
         default: ;
      endcase
      rvld_d = rd_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CAL;
         cal_cnt_q  <= '0;
         base_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         rdy_q      <= 1'b0;
         rvld_q     <= 1'b0;
         cal_ok_q   <= 1'b0;
         cal_fail_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cal_cnt_q  <= cal_cnt_d;
         base_q     <= base_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rdy_q      <= rdy_d;
         rvld_q     <= rvld_d;
         cal_ok_q   <= cal_ok_d;
         cal_fail_q <= cal_fail_d;
      end
   end

   ddr_amm_resp_ram #(.MEM_AW(MEM_AW)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_be   (amm_byteenable),
      .wr_dat  (amm_writedata),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_dat  (amm_readdata)
   );

   assign amm_ready         = rdy_q;
   assign amm_readdatavalid = rvld_q;
   assign local_cal_success = cal_ok_q;
   assign ram_ready         = cal_ok_q;
   assign local_cal_fail    = cal_fail_q;

`ifdef AMM_RESP_PROTOCOL_CHECK_EN
   logic perr_q, perr_d;
   logic bc_bad;

   always_comb begin
      bc_bad = (amm_burstcount == '0) || (amm_burstcount > AMM_BC_W'(MAX_BURST));
      perr_d = perr_q;
      case (state_q)
         ST_IDLE:         if (((acc_wr || acc_rd) && bc_bad) || (amm_write && amm_read)) perr_d = 1'b1;
         ST_WR_BURST:     if (amm_read) perr_d = 1'b1;
         ST_CAL, ST_FAIL: if (amm_read || amm_write) perr_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perr_q <= 1'b0;
      else        perr_q <= perr_d;
   end

   assign protocol_err = perr_q;
`endif

endmodule

// File: tb/tb_ddr_amm_responder.sv
// Scoreboarded bench: random bursts against a word-array memory model plus a CAL_FAIL instance.
`timescale 1ns/1ps
module tb_ddr_amm_responder;
   import ddr_amm_resp_pkg::*;

   localparam int DEPTH = 1024;
   localparam int CALC  = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [24:0]  amm_addr;
   logic [255:0] amm_writedata;
   logic [31:0]  amm_byteenable;
   logic         amm_write, amm_read;
   logic [6:0]   amm_burstcount;
   logic         rdy, rv, succ, cfail, ramrdy;
   logic [255:0] rdata;
   logic         fd_ready, fd_rv, fd_succ, fd_fail, fd_ramrdy;
   logic [255:0] fd_rdata;
`ifdef AMM_RESP_PROTOCOL_CHECK_EN
   logic         perr, fd_perr;
`endif

   ddr_amm_responder #(.MEM_AW(10), .CAL_CYCLES(CALC), .CAL_FAIL(0)) dut (
      .clk(clk), .rst_n(rst_n), .amm_addr(amm_addr), .amm_writedata(amm_writedata),
      .amm_byteenable(amm_byteenable), .amm_write(amm_write), .amm_read(amm_read),
      .amm_burstcount(amm_burstcount), .amm_ready(rdy), .amm_readdata(rdata),
      .amm_readdatavalid(rv), .local_cal_success(succ), .local_cal_fail(cfail),
      .ram_ready(ramrdy)
`ifdef AMM_RESP_PROTOCOL_CHECK_EN
      , .protocol_err(perr)
`endif
   );

   ddr_amm_responder #(.MEM_AW(10), .CAL_CYCLES(8), .CAL_FAIL(1)) dut_fail (
      .clk(clk), .rst_n(rst_n), .amm_addr(amm_addr), .amm_writedata(amm_writedata),
      .amm_byteenable(amm_byteenable), .amm_write(amm_write), .amm_read(amm_read),
      .amm_burstcount(amm_burstcount), .amm_ready(fd_ready), .amm_readdata(fd_rdata),
      .amm_readdatavalid(fd_rv), .local_cal_success(fd_succ), .local_cal_fail(fd_fail),
      .ram_ready(fd_ramrdy)
`ifdef AMM_RESP_PROTOCOL_CHECK_EN
      , .protocol_err(fd_perr)
`endif
   );

   int checks = 0;
   int failures = 0;
   int fd_bad = 0;
   logic [255:0] model [DEPTH];
   logic [255:0] exp_q [$];
   logic [255:0] pat_dat [64];
   logic [31:0]  pat_be [64];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Beats per burst as the master sees them: 0 is one beat, 65..127 wrap to 1..63.
   function automatic int ref_len(input int bc);
      if (bc == 0) return 1;
      if (bc > MAX_BURST) return bc - MAX_BURST;
      return bc;
   endfunction

   always @(negedge clk) begin
      if (rst_n && rv) begin
         if (exp_q.size() == 0) chk("rd_unexpected_beat", 256'd1, 256'd0);
         else chk("rd_data", rdata, exp_q.pop_front());
      end
      if (fd_ready || fd_rv) fd_bad++;
   end

   task automatic drive_idle();
      amm_write      = 1'b0;
      amm_read       = 1'b0;
      amm_addr       = 25'($urandom);
      amm_burstcount = 7'($urandom);
      amm_writedata  = '0;
      amm_byteenable = 32'($urandom);
   endtask

   task automatic rand_pat(input bit full_be);
      for (int k = 0; k < 64; k++) begin
         for (int i = 0; i < 8; i++) pat_dat[k][32*i +: 32] = $urandom;
         pat_be[k] = full_be ? 32'hFFFF_FFFF : $urandom;
      end
   endtask

   // Leaves the last beat on the bus; the next task's first cycle replaces it.
   task automatic wr_burst(input logic [24:0] addr, input int bc, input bit gaps, input bit with_rd);
      int n, w;
      n = ref_len(bc);
      for (int k = 0; k < n; k++) begin
         @(negedge clk); drive_idle();
         while (gaps && $urandom_range(3) == 0) begin
            @(negedge clk); drive_idle();
         end
         amm_write      = 1'b1;
         amm_writedata  = pat_dat[k];
         amm_byteenable = pat_be[k];
         if (k == 0) begin
            amm_addr       = addr;
            amm_burstcount = 7'(bc);
            amm_read       = with_rd;
         end else begin
            amm_read = 1'($urandom);
         end
         w = (int'(addr[9:0]) + k) % DEPTH;
         for (int b = 0; b < 32; b++)
            if (pat_be[k][b]) model[w][8*b +: 8] = pat_dat[k][8*b +: 8];
      end
   endtask

   task automatic rd_burst(input logic [24:0] addr, input int bc);
      int n, vbad, rbad;
      n = ref_len(bc); vbad = 0; rbad = 0;
      @(negedge clk); drive_idle();
      chk("rd_cmd_ready", 256'(rdy), 256'd1);
      amm_read       = 1'b1;
      amm_addr       = addr;
      amm_burstcount = 7'(bc);
      for (int k = 0; k < n; k++) exp_q.push_back(model[(int'(addr[9:0]) + k) % DEPTH]);
      for (int j = 1; j <= n + 2; j++) begin
         @(negedge clk); drive_idle();
         if (rv !== (j >= 2 && j <= n + 1)) vbad++;
         if (rdy !== (j == n + 2)) rbad++;
      end
      chk("rd_vld_window_badcycles", 256'(vbad), 256'd0);
      chk("rd_ready_window_badcycles", 256'(rbad), 256'd0);
   endtask

   task automatic wait_cal();
      int cyc, zbad;
      cyc = 0; zbad = 0;
      while (rdy !== 1'b1 && cyc < 300) begin
         @(negedge clk); cyc++;
         if (rdy !== 1'b1 && ({succ, cfail, ramrdy, rv} !== 4'b0 || rdata !== '0)) zbad++;
      end
      chk("cal_cycles", 256'(cyc), 256'(CALC));
      chk("cal_outputs_zero_badcycles", 256'(zbad), 256'd0);
      chk("cal_done_flags", 256'({succ, ramrdy, cfail}), 256'(3'b110));
   endtask

   initial begin
      logic [24:0] a;
      int bc, r;
      rst_n = 1'b0;
      drive_idle();
      repeat (3) @(negedge clk);
      chk("rst_outputs", 256'({rdy, rv, succ, cfail, ramrdy}), 256'd0);
      chk("rst_readdata", rdata, 256'd0);
      chk("rst_fail_inst", 256'({fd_ready, fd_rv, fd_succ, fd_fail, fd_ramrdy}), 256'd0);
      rst_n = 1'b1;
      wait_cal();
      chk("fail_inst_flags", 256'({fd_fail, fd_succ, fd_ramrdy, fd_ready}), 256'(4'b1000));
`ifdef AMM_RESP_PROTOCOL_CHECK_EN
      chk("perr_clean_after_cal", 256'(perr), 256'd0);
`endif

      for (int b = 0; b < 16; b++) begin
         rand_pat(1'b1);
         wr_burst(25'(b * 64), 64, 1'b0, 1'b0);
      end

      for (int k = 0; k < 4; k++) begin
         pat_dat[k] = 256'h0;
         pat_dat[k][7:0] = 8'hA0 + 8'(k);
         pat_be[k] = 32'hFFFF_FFFF;
      end
      wr_burst(25'h10, 4, 1'b0, 1'b0);
      rd_burst(25'h10, 4);

      pat_dat[0] = '1; pat_be[0] = 32'hFFFF_FFFF;
      wr_burst(25'd5, 1, 1'b0, 1'b0);
      pat_dat[0] = '0; pat_be[0] = 32'h0000_0001;
      wr_burst(25'd5, 1, 1'b0, 1'b0);
      rd_burst(25'd5, 1);

      rand_pat(1'b1);
      wr_burst(25'd1022, 3, 1'b0, 1'b0);
      rd_burst(25'd1022, 3);
      rd_burst(25'd0, 1);

      rand_pat(1'b0);
      wr_burst({15'h5A5A, 10'h200}, 5, 1'b1, 1'b0);
      rd_burst({15'h0123, 10'h200}, 5);

      rand_pat(1'b1);
      wr_burst(25'd100, 8, 1'b1, 1'b0);
      @(negedge clk); drive_idle();
      amm_read = 1'b1; amm_addr = 25'd100; amm_burstcount = 7'd8;
      for (int k = 0; k < 8; k++) exp_q.push_back(model[100 + k]);
      repeat (3) begin @(negedge clk); drive_idle(); end
      #1 rst_n = 1'b0;
      #1 chk("mid_read_reset_outputs", 256'({rdy, rv, succ, ramrdy}), 256'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_cal();
`ifdef AMM_RESP_PROTOCOL_CHECK_EN
      chk("perr_cleared_by_reset", 256'(perr), 256'd0);
`endif
      rd_burst(25'd100, 8);

      rand_pat(1'b1);
      wr_burst(25'd300, 0, 1'b0, 1'b0);
      rd_burst(25'd300, 0);
      wr_burst(25'd400, 100, 1'b1, 1'b0);
      rd_burst(25'd400, 127);
      rand_pat(1'b1);
      wr_burst(25'd600, 2, 1'b0, 1'b1);
      rd_burst(25'd600, 2);
      rd_burst(25'd960, 64);

      for (int it = 0; it < 60; it++) begin
         a  = 25'($urandom);
         r  = $urandom_range(9);
         bc = (r == 0) ? $urandom_range(127) : $urandom_range(16, 1);
         if ($urandom_range(1) == 1) begin
            rand_pat(1'b0);
            wr_burst(a, bc, 1'b1, r == 1);
         end else begin
            rd_burst(a, bc);
         end
      end

      @(negedge clk); drive_idle();
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
      chk("fail_inst_never_ready", 256'(fd_bad), 256'd0);
      chk("fail_inst_end_flags", 256'({fd_fail, fd_succ, fd_ramrdy}), 256'(3'b100));
      chk("fail_inst_readdata", fd_rdata, 256'd0);
      chk("main_flags_held", 256'({rdy, succ, ramrdy, cfail}), 256'(4'b1110));
`ifdef AMM_RESP_PROTOCOL_CHECK_EN
      chk("perr_set_by_violations", 256'(perr), 256'd1);
      chk("fail_inst_perr", 256'(fd_perr), 256'd1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
